gcm_ghash_ctrl: RTL and testbench
=================================

# gcm_ghash_ctrl

Sequential GHASH controller for the AES-GCM core. It replaces the single-cycle combinational GF(2^128) product, which does not fit the Basys3 LUT budget, with an iterative digit-serial multiplier. The multiplier is shared across every block of a message. It accepts 128-bit blocks over a valid/ready handshake, accumulates Y = (Y xor X)·H, and on the last block presents tag = Y xor EJ0 to the display path.

## Interface
Parameters:
- DIGIT, 4: multiplier bits consumed per cycle; legal values 1, 2, 4, 8. N = 128/DIGIT cycles per block.

Ports:
- clk  in  1  system clock (clk_out domain); single clock.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle pulse; latches i_h and i_ej0, clears Y, begins a message.
- i_h  in  [0:127]  hash subkey H = E(K, 0^128); sampled only on i_start.
- i_ej0  in  [0:127]  E(K, J0); sampled only on i_start.
- i_blk_valid  in  1  block offered.
- i_blk  in  [0:127]  AAD, ciphertext or length block; bit 0 = GCM bit 0 (MSB).
- i_blk_last  in  1  qualifies i_blk as the final block (the len(A)||len(C) block).
- o_blk_ready  out  1  controller can accept a block this cycle.
- o_busy  out  1  message in progress (any state except IDLE and DONE).
- o_tag  out  [0:127]  Y xor EJ0; valid from o_tag_valid until next i_start or reset.
- o_tag_valid  out  1  one-cycle pulse when o_tag updates.

## Operation
- States: IDLE, WAIT_BLK, MULT, DONE.
- Reset values: state IDLE, o_blk_ready 0, o_busy 0, o_tag 0, o_tag_valid 0, Y 0, counter 0.
- i_start has priority in every state, including MULT. It latches H and EJ0, sets Y = 0, aborts any multiply in flight, and moves to WAIT_BLK. o_tag keeps its old value; no o_tag_valid pulse.
- WAIT_BLK: o_blk_ready = 1. Acceptance occurs when i_blk_valid && o_blk_ready. On acceptance, load X = Y xor i_blk, V = H, Z = 0, cnt = 0, latch last flag, and go to MULT.
- MULT: each cycle processes bits X[cnt*DIGIT +: DIGIT] in ascending index order, per SP 800-38D Alg. 1. For each bit: if X[i], Z ^= V. Then V = V>>1 (toward higher index), xor R = 0xE1 followed by 120 zeros when the pre-shift V[127] = 1.
- cnt increments each MULT cycle. On the final step (cnt = N-1), Y ← Z.
  - If the last flag is clear, go to WAIT_BLK.
  - If the last flag is set, go to DONE, o_tag ← Z xor EJ0, and pulse o_tag_valid.
- DONE: o_blk_ready 0; holds the tag. i_blk_valid is ignored.
- IDLE: i_blk_valid is ignored.
- All arithmetic is XOR-only; widths are fixed at 128, with no carries.

## Timing
- i_start at cycle t → WAIT_BLK and o_blk_ready = 1 from cycle t+1.
- Block accepted in cycle a → MULT in cycles a+1 … a+N, with o_blk_ready = 0 throughout.
- In cycle a+N+1, either o_blk_ready = 1 again, or (last block) o_tag_valid = 1 with o_tag valid.
- Throughput is one block per N+1 cycles. For DIGIT = 4: 33 cycles per block, and tag latency is 33 cycles from acceptance of the last block.
- A block offered while ready is low is not consumed. The source holds i_blk and i_blk_last stable until acceptance.
- i_start coinciding with an acceptance: i_start wins and the block is not consumed.
- i_reset mid-MULT: all registers return to reset values on the next edge. o_tag is cleared to 0.

## Structure
- Package gcm_pkg holds:
  - typedef gcm_blk_t = logic [0:127];
  - constant GCM_R = 0xE1 followed by 120 zeros;
  - enum ghash_state_t {IDLE, WAIT_BLK, MULT, DONE}.
- Sub-module gf128_digit_step (combinational, parameter DIGIT): inputs Z, V, and DIGIT bits of X; outputs next Z and next V. gcm_ghash_ctrl owns the FSM, the counter, the X/Z/V/Y/H/EJ0 registers and the handshake.
- The top level instantiates gcm_ghash_ctrl in place of the combinational product.

## Test plan
- Identity: H = 0x80 followed by 120 zeros, EJ0 = 0; one last block X = 0x0123456789abcdeffedcba9876543210 → o_tag = X, pulse exactly N+1 cycles after acceptance.
- Zero operand: H = 0; any blocks → o_tag = EJ0.
- GCM test case 2 (key 0): H = 66e94bd4ef8a2c3b884cfa59ca342b2e, EJ0 = 58e2fccefa7e3061367f1d57a4e7455a.
  - Blocks: 0388dace60b6a392f328c2b971b2fe78, then length block 0…0080 (last).
  - Expected: o_tag = ab6e47d42cec13bdf53a67b21257bddf. With EJ0 = 0, expected o_tag = f38cbb1ad69223dcc3457ae5b6b0f885.
- Backpressure: assert i_blk_valid during MULT and in IDLE/DONE → no extra acceptance; accepted-block count equals the number of valid&&ready cycles; the test case 2 tag is unchanged.
- Abort and reset:
  - i_start mid-MULT, then rerun test case 2 → correct tag, no o_tag_valid pulse from the aborted message.
  - i_reset mid-MULT → all outputs 0 on the next cycle.
- Parameter sweep: repeat test case 2 with DIGIT = 1, 2, 8 → same tag; latency N+1 = 129, 65, 17 cycles.

Source files
------------

// File: rtl/gcm_pkg.sv
// Shared types and constants for the GHASH controller.
package gcm_pkg;

    // Bit 0 is the GCM MSB; the index increases toward x^127.
    typedef logic [0:127] gcm_blk_t;

    // Reduction constant for x^128 + x^7 + x^2 + x + 1 in GCM bit order.
    localparam gcm_blk_t GCM_R = {8'hE1, 120'd0};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_BLK = 2'd1,
        MULT     = 2'd2,
        DONE     = 2'd3
    } ghash_state_t;

endpackage

// File: rtl/gcm_ghash_ctrl_if.sv
// Block and tag handshake between the GCM datapath and the GHASH controller.
interface gcm_ghash_ctrl_if;
    import gcm_pkg::*;

    logic     i_start;
    gcm_blk_t i_h;
    gcm_blk_t i_ej0;
    logic     i_blk_valid;
    gcm_blk_t i_blk;
    logic     i_blk_last;
    logic     o_blk_ready;
    logic     o_busy;
    gcm_blk_t o_tag;
    logic     o_tag_valid;

    modport slave (
        input  i_start, i_h, i_ej0, i_blk_valid, i_blk, i_blk_last,
        output o_blk_ready, o_busy, o_tag, o_tag_valid
    );

    modport master (
        output i_start, i_h, i_ej0, i_blk_valid, i_blk, i_blk_last,
        input  o_blk_ready, o_busy, o_tag, o_tag_valid
    );

endinterface

// File: rtl/gf128_digit_step.sv
// One cycle of the digit-serial GF(2^128) multiply: folds DIGIT bits of X into Z.
module gf128_digit_step
    import gcm_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  gcm_blk_t         z,
    input  gcm_blk_t         v,
    input  logic [0:DIGIT-1] x_bits,
    output gcm_blk_t         z_next,
    output gcm_blk_t         v_next
);

    gcm_blk_t z_acc;
    gcm_blk_t v_acc;

    always_comb begin
        z_acc = z;
        v_acc = v;
        for (int i = 0; i < DIGIT; i++) begin
            if (x_bits[i]) begin
                z_acc = z_acc ^ v_acc;
            end
            // V * x: shift toward bit 127, reduce when x^127 falls off the end
            v_acc = v_acc[127] ? ((v_acc >> 1) ^ GCM_R) : (v_acc >> 1);
        end
        z_next = z_acc;
        v_next = v_acc;
    end

endmodule

// File: rtl/gcm_ghash_ctrl.sv
// Iterative GHASH: Y = (Y ^ X) * H per block, DIGIT multiplier bits per cycle;
// tag = Y ^ EJ0 after the last block.
module gcm_ghash_ctrl
    import gcm_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic            clk,
    input  logic            i_reset,
    gcm_ghash_ctrl_if.slave bus
);
    // state    | meaning
    // IDLE     | after reset; blocks ignored until i_start
    // WAIT_BLK | ready for the next block
    // MULT     | digit-serial multiply, 128/DIGIT cycles
    // DONE     | tag held; blocks ignored until i_start

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_WAIT = WAIT_BLK;
    localparam logic [1:0] ST_MULT = MULT;
    localparam logic [1:0] ST_DONE = DONE;

    localparam int         N        = 128 / DIGIT;
    localparam logic [6:0] CNT_LAST = 7'(N - 1);

    logic [1:0] state;
    logic [6:0] cnt;
    logic       last_q;
    logic       tag_valid_q;
    gcm_blk_t   x_q;
    gcm_blk_t   z_q;
    gcm_blk_t   v_q;
    gcm_blk_t   y_q;
    gcm_blk_t   h_q;
    gcm_blk_t   ej0_q;
    gcm_blk_t   tag_q;
    gcm_blk_t   z_nxt;
    gcm_blk_t   v_nxt;

    // X is shifted toward bit 0 so the current digit always sits at the top.
    gf128_digit_step #(
        .DIGIT (DIGIT)
    ) u_step (
        .z      (z_q),
        .v      (v_q),
        .x_bits (x_q[0:DIGIT-1]),
        .z_next (z_nxt),
        .v_next (v_nxt)
    );

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            last_q      <= 1'b0;
            tag_valid_q <= 1'b0;
            x_q         <= '0;
            z_q         <= '0;
            v_q         <= '0;
            y_q         <= '0;
            h_q         <= '0;
            ej0_q       <= '0;
            tag_q       <= '0;
        end else begin
            tag_valid_q <= 1'b0;
            if (bus.i_start) begin
                // Abort anything in flight; the previous tag stays visible.
                h_q   <= bus.i_h;
                ej0_q <= bus.i_ej0;
                y_q   <= '0;
                cnt   <= '0;
                state <= ST_WAIT;
            end else begin
                case (state)
                    ST_WAIT: begin
                        if (bus.i_blk_valid) begin
                            x_q    <= y_q ^ bus.i_blk;
                            v_q    <= h_q;
                            z_q    <= '0;
                            cnt    <= '0;
                            last_q <= bus.i_blk_last;
                            state  <= ST_MULT;
                        end
                    end
                    ST_MULT: begin
                        x_q <= x_q << DIGIT;
                        z_q <= z_nxt;
                        v_q <= v_nxt;
                        cnt <= cnt + 7'd1;
                        if (cnt == CNT_LAST) begin
                            y_q <= z_nxt;
                            cnt <= '0;
                            if (last_q) begin
                                tag_q       <= z_nxt ^ ej0_q;
                                tag_valid_q <= 1'b1;
                                state       <= ST_DONE;
                            end else begin
                                state <= ST_WAIT;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.o_blk_ready = (state == ST_WAIT);
    assign bus.o_busy      = (state == ST_WAIT) || (state == ST_MULT);
    assign bus.o_tag       = tag_q;
    assign bus.o_tag_valid = tag_valid_q;

endmodule

// File: tb/tb_gcm_ghash_ctrl.sv
// Directed bench for gcm_ghash_ctrl; four instances cover DIGIT = 4, 1, 2, 8.
module tb_gcm_ghash_ctrl;
    import gcm_pkg::*;

    localparam gcm_blk_t H_TC2     = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam gcm_blk_t EJ0_TC2   = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    localparam gcm_blk_t C_TC2     = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam gcm_blk_t LEN_TC2   = 128'h00000000000000000000000000000080;
    localparam gcm_blk_t TAG_TC2   = 128'hab6e47d42cec13bdf53a67b21257bddf;
    localparam gcm_blk_t GHASH_TC2 = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
    localparam gcm_blk_t H_ONE     = 128'h80000000000000000000000000000000;
    localparam gcm_blk_t X_ID      = 128'h0123456789abcdeffedcba9876543210;

    logic       clk;
    logic       rst;
    logic       start;
    logic       last;
    gcm_blk_t   h;
    gcm_blk_t   ej0;
    gcm_blk_t   blk;
    logic       valid [4];
    logic [3:0] ready;
    logic [3:0] busy;
    logic [3:0] tag_valid;
    gcm_blk_t   tag [4];

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    int dig_tab [4] = '{4, 1, 2, 8};

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int D = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : 8;
        gcm_ghash_ctrl_if bus ();
        assign bus.i_start     = start;
        assign bus.i_h         = h;
        assign bus.i_ej0       = ej0;
        assign bus.i_blk_valid = valid[g];
        assign bus.i_blk       = blk;
        assign bus.i_blk_last  = last;
        assign ready[g]        = bus.o_blk_ready;
        assign busy[g]         = bus.o_busy;
        assign tag[g]          = bus.o_tag;
        assign tag_valid[g]    = bus.o_tag_valid;
        gcm_ghash_ctrl #(.DIGIT(D)) dut (
            .clk     (clk),
            .i_reset (rst),
            .bus     (bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic pulse_start(input gcm_blk_t hv, input gcm_blk_t ev);
        h     = hv;
        ej0   = ev;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Offer a block to instance k until accepted; returns cycles spent waiting for ready.
    task automatic send_block(input int k, input gcm_blk_t b, input logic l, output int waited);
        blk      = b;
        last     = l;
        valid[k] = 1'b1;
        waited   = 0;
        while (!ready[k] && waited < 300) begin
            tick();
            waited++;
        end
        if (waited >= 300) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout dut=%0d waited=%0d required<300", k, waited);
        end
        tick();
        valid[k] = 1'b0;
    endtask

    // Called one cycle after acceptance; lat counts cycles from the acceptance cycle.
    task automatic wait_tag(input int k, output int lat, output gcm_blk_t t);
        lat = 1;
        while (!tag_valid[k] && lat < 400) begin
            tick();
            lat++;
        end
        if (lat >= 400) begin
            checks++;
            failures++;
            $display("FAIL tag_timeout dut=%0d waited=%0d required<400", k, lat);
        end
        t = tag[k];
    endtask

    task automatic run_tc2(input int k, input gcm_blk_t ev, output gcm_blk_t t,
                           output int lat, output int gap);
        int w;
        pulse_start(H_TC2, ev);
        send_block(k, C_TC2, 1'b0, w);
        send_block(k, LEN_TC2, 1'b1, gap);
        wait_tag(k, lat, t);
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({ready[k], busy[k], tag_valid[k]} !== 3'b000 || tag[k] !== '0) begin
                failures++;
                $display("FAIL reset_outputs dut=%0d got rdy=%b busy=%b tv=%b tag=%h required all 0",
                         k, ready[k], busy[k], tag_valid[k], tag[k]);
            end
        end
        rst      = 1'b0;
        valid[0] = 1'b1;
        bad      = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (ready[0] !== 1'b0 || busy[0] !== 1'b0) bad++;
        end
        valid[0] = 1'b0;
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL idle_ignores_valid got bad_cycles=%0d required 0", bad);
        end
    endtask

    task automatic test_identity();
        int       w;
        int       lat;
        gcm_blk_t t;
        pulse_start(H_ONE, '0);
        checks++;
        if (ready[0] !== 1'b1 || busy[0] !== 1'b1) begin
            failures++;
            $display("FAIL start_to_ready got rdy=%b busy=%b required 1 1", ready[0], busy[0]);
        end
        send_block(0, X_ID, 1'b1, w);
        wait_tag(0, lat, t);
        checks++;
        if (t !== X_ID) begin
            failures++;
            $display("FAIL identity_tag got %h required %h", t, X_ID);
        end
        checks++;
        if (lat !== 33) begin
            failures++;
            $display("FAIL identity_latency got %0d required 33", lat);
        end
        tick();
        checks++;
        if ({tag_valid[0], ready[0], busy[0]} !== 3'b000 || tag[0] !== X_ID) begin
            failures++;
            $display("FAIL done_state got tv=%b rdy=%b busy=%b tag=%h required 0 0 0 %h",
                     tag_valid[0], ready[0], busy[0], tag[0], X_ID);
        end
    endtask

    task automatic test_zero_h();
        int       w;
        int       lat;
        gcm_blk_t t;
        pulse_start('0, EJ0_TC2);
        send_block(0, C_TC2, 1'b0, w);
        send_block(0, LEN_TC2, 1'b1, w);
        wait_tag(0, lat, t);
        checks++;
        if (t !== EJ0_TC2) begin
            failures++;
            $display("FAIL zero_h_tag got %h required %h", t, EJ0_TC2);
        end
    endtask

    task automatic test_tc2();
        int       lat;
        int       gap;
        gcm_blk_t t;
        run_tc2(0, EJ0_TC2, t, lat, gap);
        checks++;
        if (t !== TAG_TC2) begin
            failures++;
            $display("FAIL tc2_tag got %h required %h", t, TAG_TC2);
        end
        checks++;
        if (gap !== 32) begin
            failures++;
            $display("FAIL tc2_block_gap got %0d required 32", gap);
        end
        checks++;
        if (lat !== 33) begin
            failures++;
            $display("FAIL tc2_latency got %0d required 33", lat);
        end
        run_tc2(0, '0, t, lat, gap);
        checks++;
        if (t !== GHASH_TC2) begin
            failures++;
            $display("FAIL tc2_ghash_only got %h required %h", t, GHASH_TC2);
        end
    endtask

    task automatic test_backpressure();
        int       nacc;
        int       npulse;
        logic     acc_now;
        gcm_blk_t got;
        pulse_start(H_TC2, EJ0_TC2);
        blk      = C_TC2;
        last     = 1'b0;
        valid[0] = 1'b1;
        nacc     = 0;
        npulse   = 0;
        got      = '0;
        for (int c = 0; c < 120; c++) begin
            acc_now = ready[0] && valid[0];
            tick();
            if (acc_now) begin
                nacc++;
                if (nacc == 1) begin
                    blk  = LEN_TC2;
                    last = 1'b1;
                end
            end
            if (tag_valid[0]) begin
                npulse++;
                got = tag[0];
            end
        end
        valid[0] = 1'b0;
        checks++;
        if (nacc !== 2) begin
            failures++;
            $display("FAIL bp_accept_count got %0d required 2", nacc);
        end
        checks++;
        if (npulse !== 1) begin
            failures++;
            $display("FAIL bp_pulse_count got %0d required 1", npulse);
        end
        checks++;
        if (got !== TAG_TC2 || tag[0] !== TAG_TC2) begin
            failures++;
            $display("FAIL bp_tag got %h / %h required %h", got, tag[0], TAG_TC2);
        end
    endtask

    task automatic test_abort();
        int       w;
        int       lat;
        int       npulse;
        int       nlow;
        gcm_blk_t old;
        gcm_blk_t t;
        pulse_start(H_TC2, EJ0_TC2);
        old = tag[0];
        send_block(0, LEN_TC2, 1'b1, w);
        repeat (10) tick();
        start = 1'b1;
        tick();
        start  = 1'b0;
        npulse = 0;
        nlow   = 0;
        for (int c = 0; c < 40; c++) begin
            if (tag_valid[0]) npulse++;
            if (!ready[0] || !busy[0]) nlow++;
            tick();
        end
        checks++;
        if (npulse !== 0 || nlow !== 0) begin
            failures++;
            $display("FAIL abort_quiet got pulses=%0d not_ready=%0d required 0 0", npulse, nlow);
        end
        checks++;
        if (tag[0] !== old) begin
            failures++;
            $display("FAIL abort_tag_kept got %h required %h", tag[0], old);
        end
        blk      = C_TC2;
        last     = 1'b0;
        valid[0] = 1'b1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (ready[0] !== 1'b1) begin
            failures++;
            $display("FAIL start_beats_accept got rdy=%b required 1", ready[0]);
        end
        send_block(0, C_TC2, 1'b0, w);
        send_block(0, LEN_TC2, 1'b1, w);
        wait_tag(0, lat, t);
        checks++;
        if (t !== TAG_TC2) begin
            failures++;
            $display("FAIL abort_rerun_tag got %h required %h", t, TAG_TC2);
        end
    endtask

    task automatic test_reset_mid_mult();
        int w;
        pulse_start(H_TC2, EJ0_TC2);
        send_block(0, C_TC2, 1'b0, w);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({ready[0], busy[0], tag_valid[0]} !== 3'b000 || tag[0] !== '0) begin
            failures++;
            $display("FAIL reset_mid_mult got rdy=%b busy=%b tv=%b tag=%h required all 0",
                     ready[0], busy[0], tag_valid[0], tag[0]);
        end
    endtask

    task automatic test_sweep();
        int       lat;
        int       gap;
        gcm_blk_t t;
        for (int k = 1; k < 4; k++) begin
            run_tc2(k, EJ0_TC2, t, lat, gap);
            checks++;
            if (t !== TAG_TC2) begin
                failures++;
                $display("FAIL sweep_tag digit=%0d got %h required %h", dig_tab[k], t, TAG_TC2);
            end
            checks++;
            if (lat !== 128 / dig_tab[k] + 1 || gap !== 128 / dig_tab[k]) begin
                failures++;
                $display("FAIL sweep_timing digit=%0d got lat=%0d gap=%0d required %0d %0d",
                         dig_tab[k], lat, gap, 128 / dig_tab[k] + 1, 128 / dig_tab[k]);
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        last  = 1'b0;
        h     = '0;
        ej0   = '0;
        blk   = '0;
        for (int k = 0; k < 4; k++) valid[k] = 1'b0;

        test_reset();
        test_identity();
        test_zero_h();
        test_tc2();
        test_backpressure();
        test_abort();
        test_reset_mid_mult();
        test_sweep();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
